// File: rtl/mopshub_test_sequencer.sv
// MOPSHUB bring-up sequencer: walks buses 0..last_bus running RX / TX / RX-then-TX /
// advanced tests against the data generator, with gap timing, watchdog and pass/fail counters.
module mopshub_test_sequencer #(
  parameter int BUS_W          = 5,
  parameter int CNT_W          = 16,
  parameter int GAP_CYCLES     = 120,
  parameter int TO_W           = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [BUS_W-1:0] last_bus,
  input  logic             loop_en,
  input  logic             test_rx_end,
  input  logic             test_tx_end,
  input  logic             costum_msg_end,
  input  logic             test_err,
  output logic             test_rx,
  output logic             test_tx,
  output logic             test_advanced,
  output logic [BUS_W-1:0] bus_sel,
  output logic             endwait_all,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             timeout
);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [1:0] M_TX = 2'd1, M_RXTX = 2'd2, M_ADV = 2'd3;

  typedef enum logic [3:0] {
    IDLE, LOAD, RUN_RX, RUN_TX, RUN_ADV, ENDWAIT, GAP, NEXT, DONE
  } state_t;

  state_t           state, next_state, first_test;
  logic [1:0]       mode_q, sel_mode;
  logic [BUS_W-1:0] last_q;
  logic [TO_W-1:0]  wd_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_to_tx;
  logic             in_run, end_hit, wd_exp, accept, expire, more_buses;

  // Mode is taken live while in LOAD, since it is latched on that same edge.
  always_comb begin
    sel_mode   = (state == LOAD) ? mode : mode_q;
    first_test = RUN_RX;
    case (sel_mode)
      M_TX:    first_test = RUN_TX;
      M_ADV:   first_test = RUN_ADV;
      default: first_test = RUN_RX;
    endcase
  end

  always_comb begin
    in_run     = (state == RUN_RX) || (state == RUN_TX) || (state == RUN_ADV);
    end_hit    = ((state == RUN_RX)  && test_rx_end) ||
                 ((state == RUN_TX)  && test_tx_end) ||
                 ((state == RUN_ADV) && costum_msg_end);
    // An end pulse on the expiry cycle is counted as a normal end, not a timeout.
    wd_exp     = (TIMEOUT_CYCLES != 0) && in_run && (wd_cnt == TO_LAST) && !end_hit;
    accept     = end_hit && !abort;
    expire     = wd_exp && !abort;
    more_buses = (bus_sel < last_q) || loop_en;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    next_state = first_test;
      RUN_RX:  if (end_hit || wd_exp) next_state = ENDWAIT;
      RUN_TX,
      RUN_ADV: if (end_hit || wd_exp) next_state = NEXT;
      ENDWAIT: begin
        if (mode_q == M_RXTX) next_state = (GAP_CYCLES == 0) ? RUN_TX : GAP;
        else                  next_state = NEXT;
      end
      GAP:     if (gap_cnt == GAP_LAST) next_state = gap_to_tx ? RUN_TX : first_test;
      NEXT: begin
        if (more_buses) next_state = (GAP_CYCLES == 0) ? first_test : GAP;
        else            next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort && state != IDLE) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      mode_q        <= '0;
      last_q        <= '0;
      wd_cnt        <= '0;
      gap_cnt       <= '0;
      gap_to_tx     <= 1'b0;
      test_rx       <= 1'b0;
      test_tx       <= 1'b0;
      test_advanced <= 1'b0;
      bus_sel       <= '0;
      endwait_all   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass_cnt      <= '0;
      fail_cnt      <= '0;
      timeout       <= 1'b0;
    end else begin
      state   <= next_state;
      wd_cnt  <= (in_run && next_state == state) ? wd_cnt + TO_W'(1) : '0;
      gap_cnt <= (state == GAP && next_state == GAP) ? gap_cnt + GAP_W'(1) : '0;

      // Levels trail state entry by one cycle and drop on the edge the state is left.
      test_rx       <= (state == RUN_RX)  && (next_state == RUN_RX);
      test_tx       <= (state == RUN_TX)  && (next_state == RUN_TX);
      test_advanced <= (state == RUN_ADV) && (next_state == RUN_ADV);
      endwait_all   <= (state == ENDWAIT) && !abort;
      done          <= (state == DONE) && !abort;
      busy          <= (next_state != IDLE);

      if (state == LOAD && !abort) begin
        mode_q   <= mode;
        last_q   <= last_bus;
        bus_sel  <= '0;
        pass_cnt <= '0;
        fail_cnt <= '0;
        timeout  <= 1'b0;
      end

      if (state == ENDWAIT)   gap_to_tx <= 1'b1;
      else if (state == NEXT) gap_to_tx <= 1'b0;

      if (accept) begin
        if (test_err) begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        end else begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
        end
      end else if (expire) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        timeout <= 1'b1;
      end

      if (state == NEXT && next_state != DONE && next_state != IDLE)
        bus_sel <= (bus_sel < last_q) ? bus_sel + BUS_W'(1) : '0;
    end
  end

endmodule
